mdu: RTL and testbench

Multiply/divide unit for the EX stage of the five-stage MIPS pipeline, sitting beside the ALU and fed the same forwarded operands A/B. It executes MULT/MULTU/DIV/DIVU with fixed multi-cycle latency, owns the HI/LO registers, and serves MTHI/MTLO/MFHI/MFLO. Its `Busy`/`Start` outputs drive the hazard unit's stall of later mult/div-class instructions in ID.

---
 rtl/mdu_pkg.sv | 55 +++++
 rtl/mdu.sv | 157 +++++++++++++++
 tb/tb_mdu.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared CPU constants: ALU control codes, multiply/divide unit
//               operation encodings, default latencies and state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    // ALU control codes used by the EX-stage ALU that sits beside the MDU
    typedef enum logic [3:0] {
        ALU_AND  = 4'd0,
        ALU_OR   = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_XOR  = 4'd3,
        ALU_NOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SUB  = 4'd6,
        ALU_SLT  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_SLTU = 4'd10,
        ALU_LUI  = 4'd11
    } alu_ctrl_e;

    // Multiply/divide unit operation codes; code 7 behaves like NONE
    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_RSVD  = 3'd7
    } mdu_op_e;

    // MDU sequencing states: IDLE means counter is zero, RUN means in flight
    typedef enum logic [0:0] {
        MDU_ST_IDLE = 1'b0,
        MDU_ST_RUN  = 1'b1
    } mdu_state_e;

    // Default busy periods
    localparam int unsigned C_MDU_MULT_CYCLES = 5;
    localparam int unsigned C_MDU_DIV_CYCLES  = 10;

    // True for the four ops that start a multi-cycle operation
    function automatic logic mdu_is_start(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
// Module      : mdu
// Description : EX-stage multiply/divide unit. Executes MULT/MULTU/DIV/DIVU
//               with fixed latency, owns HI/LO and serves MTHI/MTLO/MFHI/MFLO.
//               The result is computed in one shot at start; the counter only
//               models latency before the result is committed to HI/LO.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = C_MDU_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = C_MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  MDUOp,
    output logic        Start,
    output logic        Busy,
    input  logic        RdSel,
    output logic [31:0] MDUOut,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned C_MAX_CYCLES =
        (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W = $clog2(C_MAX_CYCLES + 1);

    mdu_op_e      op_d;
    mdu_state_e   state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]  hi_q;
    logic [31:0]  lo_q;
    logic [31:0]  th_q;
    logic [31:0]  tl_q;
    logic         commit_q;     // cleared for divide-by-zero so HI/LO stay put

    logic [31:0]  th_d;
    logic [31:0]  tl_d;
    logic         commit_d;
    logic [CNT_W-1:0] load_cnt_d;

    logic signed [63:0] prod_s;
    logic [63:0]  prod_u;
    logic [31:0]  num_mag;
    logic [31:0]  den_mag;
    logic [31:0]  den_safe;
    logic [31:0]  quo_mag;
    logic [31:0]  rem_mag;

    assign op_d   = mdu_op_e'(MDUOp);
    assign Start  = mdu_is_start(op_d);
    assign Busy   = (state_q == MDU_ST_RUN);
    assign HI     = hi_q;
    assign LO     = lo_q;
    assign MDUOut = RdSel ? hi_q : lo_q;

    // Compute the full product/quotient/remainder for the op being presented
    always_comb begin
        th_d       = 32'd0;
        tl_d       = 32'd0;
        commit_d   = 1'b1;
        load_cnt_d = CNT_W'(MULT_CYCLES);

        prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u = {32'd0, A} * {32'd0, B};

        // Signed divide works on magnitudes so the most-negative dividend
        // over -1 wraps cleanly instead of overflowing a signed divide.
        if (op_d == MDU_DIV) begin
            num_mag = A[31] ? (32'd0 - A) : A;
            den_mag = B[31] ? (32'd0 - B) : B;
        end else begin
            num_mag = A;
            den_mag = B;
        end
        den_safe = (den_mag == 32'd0) ? 32'd1 : den_mag;
        quo_mag  = num_mag / den_safe;
        rem_mag  = num_mag % den_safe;

        case (op_d)
            MDU_MULT: begin
                th_d = prod_s[63:32];
                tl_d = prod_s[31:0];
            end
            MDU_MULTU: begin
                th_d = prod_u[63:32];
                tl_d = prod_u[31:0];
            end
            MDU_DIV: begin
                tl_d       = (A[31] ^ B[31]) ? (32'd0 - quo_mag) : quo_mag;
                th_d       = A[31] ? (32'd0 - rem_mag) : rem_mag;
                commit_d   = (B != 32'd0);
                load_cnt_d = CNT_W'(DIV_CYCLES);
            end
            MDU_DIVU: begin
                tl_d       = quo_mag;
                th_d       = rem_mag;
                commit_d   = (B != 32'd0);
                load_cnt_d = CNT_W'(DIV_CYCLES);
            end
            default: begin
                th_d = 32'd0;
                tl_d = 32'd0;
            end
        endcase
    end

    // Sequencer: accepts ops only when idle, counts latency, commits HI/LO
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= MDU_ST_IDLE;
            cnt_q    <= '0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            th_q     <= 32'd0;
            tl_q     <= 32'd0;
            commit_q <= 1'b0;
        end else begin
            case (state_q)
                MDU_ST_IDLE: begin
                    if (Start) begin
                        th_q     <= th_d;
                        tl_q     <= tl_d;
                        commit_q <= commit_d;
                        cnt_q    <= load_cnt_d;
                        state_q  <= MDU_ST_RUN;
                    end else if (op_d == MDU_MTHI) begin
                        hi_q <= A;
                    end else if (op_d == MDU_MTLO) begin
                        lo_q <= A;
                    end
                end
                MDU_ST_RUN: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= MDU_ST_IDLE;
                        if (commit_q) begin
                            hi_q <= th_q;
                            lo_q <= tl_q;
                        end
                    end
                end
                default: begin
                    state_q <= MDU_ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule : mdu
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu
// Description : Self-checking bench for mdu with directed scenarios and a
//               randomized sequence compared against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu;

    localparam int C_MULT = 5;
    localparam int C_DIV  = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  MDUOp;
    logic        RdSel;
    logic        Start;
    logic        Busy;
    logic [31:0] MDUOut;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference architectural state
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    always #5 clk = ~clk;

    mdu #(.MULT_CYCLES(C_MULT), .DIV_CYCLES(C_DIV)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A      (A),
        .B      (B),
        .MDUOp  (MDUOp),
        .Start  (Start),
        .Busy   (Busy),
        .RdSel  (RdSel),
        .MDUOut (MDUOut),
        .HI     (HI),
        .LO     (LO)
    );

    // Reference model: updates m_hi/m_lo, returns expected busy length
    function automatic int model_apply(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; return C_MULT; end
            3'd2: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; return C_MULT; end
            3'd3: begin
                if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
                return C_DIV;
            end
            3'd4: begin
                if (b != 0) begin m_lo = a / b; m_hi = a % b; end
                return C_DIV;
            end
            3'd5: begin m_hi = a; return 0; end
            3'd6: begin m_lo = a; return 0; end
            default: return 0;
        endcase
    endfunction

    // Present one op for one cycle, then count Busy cycles (bounded)
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int busy_cycles);
        @(negedge clk);
        MDUOp = op; A = a; B = b;
        @(negedge clk);
        MDUOp = 3'd0;
        busy_cycles = 0;
        while (Busy === 1'b1 && busy_cycles < 100) begin
            busy_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; MDUOp = 3'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: Busy=%b HI=%h LO=%h, required 0/0/0", Busy, HI, LO);
        end
    endtask

    task automatic test_start();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            MDUOp = 3'(i); A = 32'd0; B = 32'd1;
            #1;
            n_checks++;
            if (Start !== (i >= 1 && i <= 4)) begin
                n_fail++;
                $display("FAIL start_decode op=%0d: Start=%b, required %b", i, Start, (i >= 1 && i <= 4));
            end
            MDUOp = 3'd0;
            // let any started op finish before presenting the next code
            repeat (12) @(negedge clk);
        end
        apply_reset();
    endtask

    task automatic test_mult();
        int bc;
        do_op(3'd1, 32'hFFFFFFFD, 32'd7, bc);
        n_checks++;
        if (bc !== 5 || HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFEB) begin
            n_fail++;
            $display("FAIL mult_signed: busy=%0d HI=%h LO=%h, required 5 FFFFFFFF FFFFFFEB", bc, HI, LO);
        end
        do_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, bc);
        n_checks++;
        if (bc !== 5 || HI !== 32'hFFFFFFFE || LO !== 32'h00000001) begin
            n_fail++;
            $display("FAIL multu: busy=%0d HI=%h LO=%h, required 5 FFFFFFFE 00000001", bc, HI, LO);
        end
        RdSel = 1'b1; #1;
        n_checks++;
        if (MDUOut !== 32'hFFFFFFFE) begin
            n_fail++;
            $display("FAIL mfhi_read: MDUOut=%h, required FFFFFFFE", MDUOut);
        end
        RdSel = 1'b0; #1;
        n_checks++;
        if (MDUOut !== 32'h00000001) begin
            n_fail++;
            $display("FAIL mflo_read: MDUOut=%h, required 00000001", MDUOut);
        end
    endtask

    task automatic test_div();
        int bc;
        do_op(3'd3, 32'hFFFFFFF9, 32'd2, bc);
        n_checks++;
        if (bc !== 10 || LO !== 32'hFFFFFFFD || HI !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL div_signed: busy=%0d HI=%h LO=%h, required 10 FFFFFFFF FFFFFFFD", bc, HI, LO);
        end
        do_op(3'd4, 32'hFFFFFFF9, 32'd2, bc);
        n_checks++;
        if (bc !== 10 || LO !== 32'h7FFFFFFC || HI !== 32'h00000001) begin
            n_fail++;
            $display("FAIL divu: busy=%0d HI=%h LO=%h, required 10 00000001 7FFFFFFC", bc, HI, LO);
        end
    endtask

    task automatic test_mt_and_divzero();
        int bc;
        @(negedge clk);
        MDUOp = 3'd5; A = 32'h1234;
        @(posedge clk); #1;
        n_checks++;
        if (HI !== 32'h1234 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mthi_timing: HI=%h Busy=%b, required 00001234 0", HI, Busy);
        end
        @(negedge clk);
        MDUOp = 3'd6; A = 32'h5678;
        @(negedge clk);
        MDUOp = 3'd0;
        n_checks++;
        if (LO !== 32'h5678) begin
            n_fail++;
            $display("FAIL mtlo: LO=%h, required 00005678", LO);
        end
        do_op(3'd4, 32'd9, 32'd0, bc);
        n_checks++;
        if (bc !== 10 || HI !== 32'h1234 || LO !== 32'h5678) begin
            n_fail++;
            $display("FAIL divu_by_zero: busy=%0d HI=%h LO=%h, required 10 00001234 00005678", bc, HI, LO);
        end
        do_op(3'd3, 32'hFFFFFFF0, 32'd0, bc);
        n_checks++;
        if (bc !== 10 || HI !== 32'h1234 || LO !== 32'h5678) begin
            n_fail++;
            $display("FAIL div_by_zero: busy=%0d HI=%h LO=%h, required 10 00001234 00005678", bc, HI, LO);
        end
    endtask

    task automatic test_ops_while_busy();
        int bc;
        logic [31:0] old_lo;
        old_lo = LO;
        bc = 0;
        @(negedge clk);
        MDUOp = 3'd1; A = 32'd3; B = 32'd4;        // cycle T
        @(negedge clk);                            // busy cycle 1
        MDUOp = 3'd0;
        if (Busy === 1'b1) bc++;
        @(negedge clk);                            // busy cycle 2
        if (Busy === 1'b1) bc++;
        MDUOp = 3'd6; A = 32'hAAAA;
        RdSel = 1'b0; #1;
        n_checks++;
        if (MDUOut !== old_lo) begin
            n_fail++;
            $display("FAIL read_during_busy: MDUOut=%h, required %h", MDUOut, old_lo);
        end
        @(negedge clk);                            // busy cycle 3
        if (Busy === 1'b1) bc++;
        MDUOp = 3'd3; A = 32'd8; B = 32'd2;
        @(negedge clk);
        MDUOp = 3'd0;
        for (int i = 0; i < 12; i++) begin
            if (Busy === 1'b1) bc++;
            @(negedge clk);
        end
        n_checks++;
        if (bc !== 5 || LO !== 32'd12 || HI !== 32'd0) begin
            n_fail++;
            $display("FAIL ops_while_busy: busy=%0d HI=%h LO=%h, required 5 00000000 0000000C", bc, HI, LO);
        end
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        MDUOp = 3'd5; A = 32'hDEAD;                // make HI nonzero first
        @(negedge clk);
        MDUOp = 3'd1; A = 32'd5; B = 32'd5;
        @(negedge clk);                            // busy cycle 1
        MDUOp = 3'd0;
        @(negedge clk);                            // busy cycle 2
        @(negedge clk);                            // busy cycle 3
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_op: Busy=%b HI=%h LO=%h, required 0 0 0", Busy, HI, LO);
        end
        repeat (8) @(negedge clk);
        n_checks++;
        if (LO !== 32'd0 || HI !== 32'd0 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL no_late_write: Busy=%b HI=%h LO=%h, required 0 0 0", Busy, HI, LO);
        end
        m_hi = 32'd0; m_lo = 32'd0;
    endtask

    task automatic test_random();
        int          bc, exp_bc;
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(1, 6));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 :
                 ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if ($urandom_range(0, 5) == 0) a = 32'h80000000;
            if ($urandom_range(0, 5) == 0) b = 32'hFFFFFFFF;
            exp_bc = model_apply(op, a, b);
            do_op(op, a, b, bc);
            n_checks++;
            if (bc !== exp_bc || HI !== m_hi || LO !== m_lo) begin
                n_fail++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: busy=%0d HI=%h LO=%h, required %0d %h %h",
                         i, op, a, b, bc, HI, LO, exp_bc, m_hi, m_lo);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; A = 32'd0; B = 32'd0; MDUOp = 3'd0; RdSel = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        test_reset();
        test_start();
        test_mult();
        test_div();
        test_mt_and_divzero();
        test_ops_while_busy();
        test_reset_mid_op();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mdu
`default_nettype wire
